// File: rtl/gol_step_scheduler_if.sv
// ---------------------------------------------------------------------------
// gol_step_scheduler_if
//
// Start/done handshake bundle between the Game of Life step scheduler and the
// three board engines (init, update, copy).
//
// Signals:
//   init_start    scheduler -> init engine, one-cycle start pulse
//   init_mode     scheduler -> init engine, 0 = clear, 1 = random; held
//                 from init_start until init_done
//   init_done     init engine -> scheduler, one-cycle completion pulse
//   update_start  scheduler -> update engine, one-cycle start pulse
//   update_done   update engine -> scheduler, one-cycle completion pulse
//   copy_start    scheduler -> copy engine, one-cycle start pulse
//   copy_done     copy engine -> scheduler, one-cycle completion pulse
//
// Modports:
//   master  scheduler side (drives starts and mode, receives dones)
//   slave   engine side (receives starts and mode, drives dones)
// ---------------------------------------------------------------------------
interface gol_step_scheduler_if;
  logic init_start;
  logic init_mode;
  logic init_done;
  logic update_start;
  logic update_done;
  logic copy_start;
  logic copy_done;

  modport master (
    output init_start,
    output init_mode,
    output update_start,
    output copy_start,
    input  init_done,
    input  update_done,
    input  copy_done
  );

  modport slave (
    input  init_start,
    input  init_mode,
    input  update_start,
    input  copy_start,
    output init_done,
    output update_done,
    output copy_done
  );
endinterface

// File: rtl/gol_step_scheduler.sv
// ---------------------------------------------------------------------------
// gol_step_scheduler
//
// Sequencing controller for the Game of Life board engines. It produces the
// automatic step tick, latches user requests, arbitrates them by priority
// (clear > randomize > step/tick) and launches engine sequences only during
// vertical blanking so the displayed board never tears. A step is always an
// UPDATE phase followed by a COPY phase; the copy also waits for vblank.
// The generation counter counts completed copies since the last init.
//
// Optional feature (macro GOL_SCHED_WDOG_EN):
//   When defined, each engine phase (INIT, UPDATE, COPY) is guarded by a
//   cycle counter. A phase lasting more than WDOG_CYCLES cycles without its
//   done pulse is abandoned: the scheduler returns to IDLE and raises a
//   sticky err flag. When undefined, phases wait forever and err is 0.
//
// Parameters:
//   CLOCK_FREQ   clk frequency in Hz
//   STEP_HZ      automatic step rate; INTERVAL = CLOCK_FREQ/STEP_HZ cycles
//   GEN_W        generation counter width
//   WDOG_CYCLES  per-phase watchdog limit (watchdog build only)
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   run        1 = free-running steps, 0 = paused
//   step_req   single-step pulse, honoured only while run=0
//   rand_req   randomize-board pulse
//   clear_req  clear-board pulse
//   vblank     high during vertical blanking
//   eng        engine start/done handshake (master side)
//   busy       1 in any state other than IDLE
//   gen_count  generations completed since last init
//   state      IDLE=0, INIT=1, UPDATE=2, WAIT_CPY=3, COPY=4
//   err        sticky watchdog error (0 when the watchdog is not built)
// ---------------------------------------------------------------------------
module gol_step_scheduler #(
  parameter int CLOCK_FREQ  = 24000000,
  parameter int STEP_HZ     = 10,
  parameter int GEN_W       = 16,
  parameter int WDOG_CYCLES = 262144
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step_req,
  input  logic                 rand_req,
  input  logic                 clear_req,
  input  logic                 vblank,
  gol_step_scheduler_if.master eng,
  output logic                 busy,
  output logic [GEN_W-1:0]     gen_count,
  output logic [2:0]           state,
  output logic                 err
);

  localparam int INTERVAL = CLOCK_FREQ / STEP_HZ;
  localparam int TIMER_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_UPDATE   = 3'd2,
    ST_WAIT_CPY = 3'd3,
    ST_COPY     = 3'd4
  } state_e;

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [GEN_W-1:0]   gen_q;
  logic               tick_pend;
  logic               clear_pend;
  logic               rand_pend;
  logic               step_pend;
  // Set by reset so the first INIT after reset is a random fill that does
  // not wait for vblank; it also marks that init_start is still owed.
  logic               boot_pend;
  logic               wdog_trip;

`ifdef GOL_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              err_q;
  logic              in_phase;
  logic              phase_done;

  // Which states are guarded, and whether the matching done arrives now.
  // A done seen before the boot init_start has gone out does not count.
  always_comb begin
    in_phase   = 1'b0;
    phase_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        in_phase   = 1'b1;
        phase_done = eng.init_done && !boot_pend;
      end
      ST_UPDATE: begin
        in_phase   = 1'b1;
        phase_done = eng.update_done;
      end
      ST_COPY: begin
        in_phase   = 1'b1;
        phase_done = eng.copy_done;
      end
      default: begin
        in_phase   = 1'b0;
        phase_done = 1'b0;
      end
    endcase
  end

  assign wdog_trip = in_phase && !phase_done && (wdog_cnt >= WDOG_LIMIT);

  // Every guarded phase is entered from IDLE, WAIT_CPY or reset, all of
  // which hold the counter at zero, so the count always starts fresh on
  // phase entry. A trip also zeroes it because it leads straight to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wdog_trip) begin
        err_q <= 1'b1;
      end
      if (in_phase && !wdog_trip) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end else begin
        wdog_cnt <= '0;
      end
    end
  end

  assign err = err_q;
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  // Main sequencer: step timer, request latches and phase FSM share one
  // block because a launch has to consume the very request that caused it.
  // Statements later in the block override earlier ones, which is how a
  // launch wins over a same-cycle pulse of the same kind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_INIT;
      boot_pend        <= 1'b1;
      eng.init_start   <= 1'b0;
      eng.update_start <= 1'b0;
      eng.copy_start   <= 1'b0;
      eng.init_mode    <= 1'b1;
      gen_q            <= '0;
      timer_q          <= '0;
      tick_pend        <= 1'b0;
      clear_pend       <= 1'b0;
      rand_pend        <= 1'b0;
      step_pend        <= 1'b0;
    end else begin
      eng.init_start   <= 1'b0;
      eng.update_start <= 1'b0;
      eng.copy_start   <= 1'b0;

      // Step timer: counts only while running and parks at the last value
      // with a pending tick, so a long non-blank stretch yields one tick.
      if (!run) begin
        timer_q   <= '0;
        tick_pend <= 1'b0;
      end else if (timer_q == TIMER_MAX) begin
        tick_pend <= 1'b1;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      if (clear_req) begin
        clear_pend <= 1'b1;
      end
      if (rand_req) begin
        rand_pend <= 1'b1;
      end
      if (step_req && !run) begin
        step_pend <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (vblank) begin
            if (clear_pend) begin
              state_q        <= ST_INIT;
              eng.init_mode  <= 1'b0;
              eng.init_start <= 1'b1;
              clear_pend     <= 1'b0;
            end else if (rand_pend) begin
              state_q        <= ST_INIT;
              eng.init_mode  <= 1'b1;
              eng.init_start <= 1'b1;
              rand_pend      <= 1'b0;
            end else if (step_pend || tick_pend) begin
              state_q          <= ST_UPDATE;
              eng.update_start <= 1'b1;
              step_pend        <= 1'b0;
              tick_pend        <= 1'b0;
              timer_q          <= '0;
            end
          end
        end

        ST_INIT: begin
          if (boot_pend) begin
            eng.init_start <= 1'b1;
            boot_pend      <= 1'b0;
          end else if (eng.init_done) begin
            state_q <= ST_IDLE;
            gen_q   <= '0;
            // The board was just cleared/randomized, so an older request of
            // that same kind is satisfied; a pulse arriving right now is a
            // fresh request and is kept.
            if (eng.init_mode) begin
              rand_pend <= rand_req;
            end else begin
              clear_pend <= clear_req;
            end
          end else if (wdog_trip) begin
            state_q <= ST_IDLE;
          end
        end

        ST_UPDATE: begin
          if (eng.update_done) begin
            state_q <= ST_WAIT_CPY;
          end else if (wdog_trip) begin
            state_q <= ST_IDLE;
          end
        end

        ST_WAIT_CPY: begin
          if (vblank) begin
            state_q        <= ST_COPY;
            eng.copy_start <= 1'b1;
          end
        end

        ST_COPY: begin
          if (eng.copy_done) begin
            state_q <= ST_IDLE;
            gen_q   <= gen_q + 1'b1;
          end else if (wdog_trip) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_gol_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gol_step_scheduler
//
// Scoreboard bench for gol_step_scheduler. Each scenario works out, from the
// request rules (clear > randomize > step/tick, one step = update then copy,
// init zeroes the generation count), which engine launches must follow and
// queues them with the generation count expected once each one finishes. A
// monitor pops an entry for every start pulse the scheduler emits. Engine
// models answer every start with a done pulse five cycles later.
// Built with GOL_SCHED_WDOG_EN, it also withholds an update_done to exercise
// the watchdog.
// ---------------------------------------------------------------------------
module tb_gol_step_scheduler;

  localparam int GEN_W    = 16;
  localparam int K_INIT   = 0;
  localparam int K_UPDATE = 1;
  localparam int K_COPY   = 2;

  typedef struct {
    int kind;
    int mode;
    int gen_after;
  } exp_t;

  exp_t exp_q[$];

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             run       = 1'b0;
  logic             step_req  = 1'b0;
  logic             rand_req  = 1'b0;
  logic             clear_req = 1'b0;
  logic             vblank    = 1'b0;
  logic             busy;
  logic [GEN_W-1:0] gen_count;
  logic [2:0]       state;
  logic             err;

  int checks    = 0;
  int passes    = 0;
  int model_gen = 0;
  int last_gen  = 0;
  int last_mode = 1;
  int last_kind = -1;
  bit prev_busy = 1'b1;
  bit withhold_update = 1'b0;
  int eng_cnt[3];

  gol_step_scheduler_if eng_if();

  gol_step_scheduler #(
    .CLOCK_FREQ (100),
    .STEP_HZ    (10),
    .GEN_W      (GEN_W),
    .WDOG_CYCLES(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .step_req (step_req),
    .rand_req (rand_req),
    .clear_req(clear_req),
    .vblank   (vblank),
    .eng      (eng_if),
    .busy     (busy),
    .gen_count(gen_count),
    .state    (state),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Hard stop in case the scheduler wedges somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no end of test, expected end before 50000 cycles");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic push_exp(input int kind, input int mode, input int gen_after);
    exp_t e;
    e.kind = kind;
    e.mode = mode;
    e.gen_after = gen_after;
    exp_q.push_back(e);
  endtask

  task automatic pop_start(input int kind, input int mode);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_start: got launch kind %0d, expected no launch", kind);
    end else begin
      e = exp_q.pop_front();
      checkOutput("start_kind", kind, e.kind);
      if (kind == K_INIT) checkOutput("init_mode", mode, e.mode);
      last_kind = e.kind;
      last_mode = e.mode;
      last_gen  = e.gen_after;
    end
  endtask

  // Engine models: done pulse five cycles after the start pulse.
  always @(negedge clk) begin
    eng_if.init_done   = 1'b0;
    eng_if.update_done = 1'b0;
    eng_if.copy_done   = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) eng_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (eng_cnt[i] > 0) begin
          eng_cnt[i]--;
          if (eng_cnt[i] == 0) begin
            case (i)
              0: eng_if.init_done = 1'b1;
              1: eng_if.update_done = 1'b1;
              default: eng_if.copy_done = 1'b1;
            endcase
          end
        end
      end
      if (eng_if.init_start) eng_cnt[0] = 5;
      if (eng_if.update_start && !withhold_update) eng_cnt[1] = 5;
      if (eng_if.copy_start) eng_cnt[2] = 5;
    end
  end

  // Monitor: sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_busy = 1'b1;
      last_kind = -1;
    end else begin
      if (eng_if.init_start)   pop_start(K_INIT, int'(eng_if.init_mode));
      if (eng_if.update_start) pop_start(K_UPDATE, 0);
      if (eng_if.copy_start)   pop_start(K_COPY, 0);
      if (state == 3'd1 && last_kind == K_INIT)
        checkOutput("init_mode_held", int'(eng_if.init_mode), last_mode);
      if (prev_busy && !busy) checkOutput("gen_after_seq", int'(gen_count), last_gen);
      prev_busy = busy;
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit c, input bit r, input bit s);
    @(negedge clk);
    clear_req = c;
    rand_req  = r;
    step_req  = s;
    @(negedge clk);
    clear_req = 1'b0;
    rand_req  = 1'b0;
    step_req  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(exp_q.size() == 0 && !busy), 1);
  endtask

  function automatic bit start_of(input int kind);
    case (kind)
      K_INIT:   return eng_if.init_start;
      K_UPDATE: return eng_if.update_start;
      default:  return eng_if.copy_start;
    endcase
  endfunction

  task automatic wait_start(input int kind);
    int n = 0;
    while (!start_of(kind) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_seen", int'(start_of(kind)), 1);
  endtask

  task automatic push_step();
    push_exp(K_UPDATE, 0, model_gen);
    model_gen = (model_gen + 1) % (1 << GEN_W);
    push_exp(K_COPY, 0, model_gen);
  endtask

  // Paused board: requests latched outside blanking, served by priority once
  // vblank rises, nothing more afterwards.
  task automatic scenario_requests(input bit c, input bit r, input bit s);
    vblank = 1'b0;
    if (c) begin push_exp(K_INIT, 0, 0); model_gen = 0; end
    if (r) begin push_exp(K_INIT, 1, 0); model_gen = 0; end
    if (s) push_step();
    applyStimulus(c, r, s);
    wait_cycles($urandom_range(1, 8));
    checkOutput("no_launch_outside_vblank", int'(busy), 0);
    vblank = 1'b1;
    wait_idle("req_drain");
    wait_cycles(12);
    vblank = 1'b0;
  endtask

  // Running board held outside blanking: many tick intervals collapse into
  // exactly one step; a step pulse while running is ignored.
  task automatic scenario_tick();
    push_step();
    @(negedge clk);
    run = 1'b1;
    if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles($urandom_range(15, 45));
    checkOutput("no_launch_outside_vblank", int'(busy), 0);
    vblank = 1'b1;
    wait_start(K_COPY);
    vblank = 1'b0;
    wait_idle("tick_drain");
    run = 1'b0;
    wait_cycles(2);
  endtask

  // Clear and randomize arrive together during an update: the step finishes,
  // then clear, then randomize.
  task automatic scenario_busy_requests();
    push_step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    vblank = 1'b1;
    wait_start(K_UPDATE);
    wait_cycles(2);
    push_exp(K_INIT, 0, 0);
    push_exp(K_INIT, 1, 0);
    model_gen = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    wait_idle("busy_req_drain");
    wait_cycles(12);
    vblank = 1'b0;
  endtask

  task automatic scenario_reset_in_copy();
    push_step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    vblank = 1'b1;
    wait_start(K_COPY);
    wait_cycles(2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_state_init", int'(state), 1);
    checkOutput("rst_gen_zero", int'(gen_count), 0);
    checkOutput("rst_copy_start_low", int'(eng_if.copy_start), 0);
    checkOutput("rst_init_mode", int'(eng_if.init_mode), 1);
    checkOutput("rst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    model_gen = 0;
    vblank = 1'b0;
    push_exp(K_INIT, 1, 0);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_idle("boot_after_reset");
    checkOutput("state_idle_after_boot", int'(state), 0);
  endtask

  initial begin
    $display("[TB] start");
    wait_cycles(3);
    checkOutput("reset_state_init", int'(state), 1);
    checkOutput("reset_busy", int'(busy), 1);
    checkOutput("reset_init_start", int'(eng_if.init_start), 0);
    checkOutput("reset_update_start", int'(eng_if.update_start), 0);
    checkOutput("reset_init_mode", int'(eng_if.init_mode), 1);
    checkOutput("reset_gen", int'(gen_count), 0);
    checkOutput("reset_err", int'(err), 0);
    push_exp(K_INIT, 1, 0);
    rst_n = 1'b1;
    wait_idle("boot_init");
    checkOutput("boot_state_idle", int'(state), 0);

    scenario_requests(1'b0, 1'b0, 1'b1);
    scenario_tick();
    scenario_tick();
    scenario_requests(1'b1, 1'b1, 1'b1);
    scenario_busy_requests();
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: scenario_requests(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
        1: scenario_tick();
        default: scenario_busy_requests();
      endcase
    end
    scenario_requests(1'b0, 1'b0, 1'b1);
    scenario_reset_in_copy();

`ifdef GOL_SCHED_WDOG_EN
    begin
      int n = 0;
      withhold_update = 1'b1;
      push_exp(K_UPDATE, 0, model_gen);
      applyStimulus(1'b0, 1'b0, 1'b1);
      vblank = 1'b1;
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput("wdog_err", int'(err), 1);
      checkOutput("wdog_state_idle", int'(state), 0);
      wait_idle("wdog_drain");
      wait_cycles(5);
      checkOutput("wdog_err_sticky", int'(err), 1);
      vblank = 1'b0;
      withhold_update = 1'b0;
    end
`else
    checkOutput("err_tied_low", int'(err), 0);
`endif

    wait_cycles(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
